eth_rx_parser: RTL and testbench
================================

Name: eth_rx_parser

Overview:
- Byte-stream Ethernet receive parser between the GMII-style PHY receive interface and the packet status register block.
- Strips preamble/SFD, extracts destination/source MAC and ARP fields (SHA, SPA, THA, TPA), and classifies the frame.
- At end of frame it emits a one-cycle packet-type pulse with all field outputs valid in that same cycle. The status block latches the fields on any non-zero type.

Parameters:
- LOCAL_MAC, 48'h02_00_00_00_00_01, station MAC address used by the destination filter.
- MAC_FILTER, 0, when 1 accept only frames whose destination is LOCAL_MAC or broadcast.
- MIN_LEN, 64, minimum frame length in bytes (after SFD, FCS included).
- MAX_LEN, 1518, maximum frame length in bytes (after SFD, FCS included).

Ports:
- clk  in  1  system clock; one byte per cycle when i_rx_dv=1.
- rst_n  in  1  asynchronous active-low reset.
- i_rx_data  in  8  receive byte.
- i_rx_dv  in  1  frame valid; high for preamble through FCS.
- i_rx_er  in  1  receive error; any assertion while dv=1 spoils the frame.
- o_dst_mac  out  48  destination MAC.
- o_src_mac  out  48  source MAC.
- o_SHA  out  48  ARP sender hardware address.
- o_SPA  out  32  ARP sender protocol address.
- o_THA  out  48  ARP target hardware address.
- o_TPA  out  32  ARP target protocol address.
- o_pkt_type  out  2  one-cycle pulse: 01 ARP request, 10 ARP reply, 11 IPv4; otherwise 00.
- o_drop_cnt  out  16  count of discarded frames; wraps at 0xFFFF→0.

Behaviour:
Byte order and field layout:
- Network order: the first byte received lands in the MSB of each field (dst_mac[47:40] first).
- Byte index n counts from 0 at the first byte after SFD. dst = 0..5, src = 6..11, ethertype = 12..13.
- ARP (ethertype 0x0806): htype = 14..15, ptype = 16..17, hlen = 18, plen = 19, oper = 20..21, SHA = 22..27, SPA = 28..31, THA = 32..37, TPA = 38..41.

Counters and registers:
- Length counter is 11 bits and saturates at 2047.
- Fields are parsed into working registers. Outputs load from the working registers only in the pulse cycle; otherwise they hold.

States:
- SKIP (reset state): wait for dv=0, then IDLE. This prevents parsing a frame already in progress when reset releases.
- IDLE: dv=1 and data=0x55 → PRE. dv=1 with any other byte → SKIP.
- PRE: 0x55 stays in PRE; 0xD5 → HDR with n=0; any other byte → SKIP with no drop count. dv=0 → IDLE with no drop count.
- HDR: capture bytes 0..13; decide the class at byte 13:
  - ARP → BODY.
  - 0x0800 → DRAIN, class IPv4.
  - Otherwise → DRAIN, class NONE.
- BODY: capture bytes 14..41, then → DRAIN.
- DRAIN: count bytes until dv=0.
- dv falling in HDR, BODY or DRAIN → END.

END (one cycle, evaluated in the cycle after dv goes low; pulse registered there):
- A frame is bad if any of these hold:
  - er was seen;
  - length < MIN_LEN or length > MAX_LEN;
  - it is ARP with n < 42 reached, or htype≠1, ptype≠0x0800, hlen≠6, plen≠4, or oper∉{1,2};
  - MAC_FILTER=1 and dst is neither LOCAL_MAC nor all-ones.
- Bad frame: o_pkt_type stays 00, o_drop_cnt+1, outputs hold.
- Good ARP frame: pulse 01 (oper=1) or 10 (oper=2) and load all fields.
- Good IPv4 frame: pulse 11, load the MACs, and drive the ARP outputs to 0.
- Class NONE, good frame: no pulse, no drop count.
- END → IDLE.

Boundaries:
- dv re-asserting in the END cycle is allowed; IDLE logic is applied to that byte in the following cycle. The PHY guarantees ≥1 idle byte between frames.
- Latency: pulse occurs exactly 1 cycle after the first dv=0 cycle of a frame.
- Reset behaviour: all outputs, o_drop_cnt and working registers clear to 0; state returns to SKIP.

Decomposition:
Shared package eth_pkg holds:
- ethertype constants: ETH_ARP = 16'h0806, ETH_IPV4 = 16'h0800;
- ARP constants: ARP_HTYPE_ETH, ARP_OPER_REQ = 1, ARP_OPER_REP = 2;
- pkt_type enum: PKT_NONE, PKT_ARP_REQ, PKT_ARP_REP, PKT_IPV4;
- state enum.

One sub-module, eth_rx_preamble, handles SKIP/IDLE/PRE and SFD detection. It outputs a byte strobe plus SOF/EOF for the field parser. Everything else is flat.

Test Plan:
- Reset with dv held high mid-frame, release, frame continues → o_pkt_type remains 00 and o_drop_cnt remains 0. The next clean frame parses normally.
- 7×0x55, 0xD5, then a 64-byte ARP request: dst FF..FF, src 02:11:22:33:44:55, SPA C0A80001, TPA C0A80002 → exactly one pulse 01 one cycle after dv falls, with o_src_mac=48'h021122334455 and o_TPA=32'hC0A80002 in the pulse cycle.
- ARP reply (oper=2) followed by an IPv4 frame → pulse 10 with fields loaded; then pulse 11 with o_SHA=o_SPA=o_THA=o_TPA=0 and new MACs.
- ARP frame with i_rx_er asserted on byte 30, then a 40-byte runt, then a 1600-byte frame → three drops: o_drop_cnt=3, no pulses, outputs unchanged from the prior good frame.
- MAC_FILTER=1: unicast to LOCAL_MAC → pulse; broadcast → pulse; unicast to 02:00:00:00:00:99 → no pulse, o_drop_cnt+1.
- Preload o_drop_cnt to 0xFFFF via 65535 runts, then send one more runt → 0x0000. An ethertype 0x86DD frame → no pulse, count unchanged.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants and types for the Ethernet receive parser.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package eth_pkg;

    localparam logic [15:0] ETH_ARP        = 16'h0806;
    localparam logic [15:0] ETH_IPV4       = 16'h0800;

    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
    localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;
    localparam logic [15:0] ARP_OPER_REQ   = 16'd1;
    localparam logic [15:0] ARP_OPER_REP   = 16'd2;

    // Byte index one past the last ARP field (TPA ends at byte 41)
    localparam logic [10:0] ARP_END_N      = 11'd42;

    typedef enum logic [1:0] {
        PKT_NONE    = 2'b00,
        PKT_ARP_REQ = 2'b01,
        PKT_ARP_REP = 2'b10,
        PKT_IPV4    = 2'b11
    } pkt_type_t;

    typedef enum logic [2:0] {
        ST_SKIP  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_PRE   = 3'd2,
        ST_HDR   = 3'd3,
        ST_BODY  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_END   = 3'd6
    } state_t;

    // Saturating increment for the 11-bit frame length counter
    function automatic logic [10:0] len_inc(input logic [10:0] n);
        return (n == 11'h7FF) ? n : n + 11'd1;
    endfunction

endpackage

// File: rtl/eth_rx_preamble.sv
// Preamble/SFD tracker: SOF on the SFD byte, byte strobe for every frame byte, EOF on the first dv=0.
// Latency: combinational strobes from registered state; EOF is asserted in the first dv=0 cycle.
// Backpressure: none; the PHY stream cannot be stalled, so every byte is consumed as it arrives.
module eth_rx_preamble
    import eth_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_dv,
    output logic       o_sof,
    output logic       o_byte_vld,
    output logic       o_eof
);

    state_t state_q, state_d;

    // Next-state and strobe decode; ST_HDR here simply means "inside a frame"
    always_comb begin
        state_d    = state_q;
        o_sof      = 1'b0;
        o_byte_vld = 1'b0;
        o_eof      = 1'b0;
        case (state_q)
            // Coming out of reset mid-frame: ignore everything until the line goes idle
            ST_SKIP: if (!i_rx_dv) state_d = ST_IDLE;
            ST_IDLE: if (i_rx_dv) state_d = (i_rx_data == 8'h55) ? ST_PRE : ST_SKIP;
            ST_PRE: begin
                if (!i_rx_dv) begin
                    state_d = ST_IDLE;
                end else if (i_rx_data == 8'hD5) begin
                    state_d = ST_HDR;
                    o_sof   = 1'b1;
                end else if (i_rx_data != 8'h55) begin
                    state_d = ST_SKIP;
                end
            end
            ST_HDR: begin
                if (i_rx_dv) begin
                    o_byte_vld = 1'b1;
                end else begin
                    o_eof   = 1'b1;
                    state_d = ST_END;
                end
            end
            // Pulse cycle in the parser; any byte arriving now is ignored
            ST_END:  state_d = ST_IDLE;
            default: state_d = ST_SKIP;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_SKIP;
        else        state_q <= state_d;
    end

endmodule

// File: rtl/eth_rx_parser.sv
// Ethernet RX parser: extracts MACs and ARP fields, classifies the frame, counts drops.
// Latency: o_pkt_type pulses one cycle after the first dv=0 cycle of a frame.
// Backpressure: none; one byte per cycle is always accepted, outputs hold between pulses.
module eth_rx_parser
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01,
    parameter bit          MAC_FILTER = 1'b0,
    parameter int          MIN_LEN    = 64,
    parameter int          MAX_LEN    = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_dv,
    input  logic        i_rx_er,
    output logic [47:0] o_dst_mac,
    output logic [47:0] o_src_mac,
    output logic [47:0] o_SHA,
    output logic [31:0] o_SPA,
    output logic [47:0] o_THA,
    output logic [31:0] o_TPA,
    output logic [1:0]  o_pkt_type,
    output logic [15:0] o_drop_cnt
);

    localparam logic [10:0] MIN_N = 11'(MIN_LEN);
    localparam logic [10:0] MAX_N = 11'(MAX_LEN);

    logic sof, byte_vld, eof;

    eth_rx_preamble u_pre (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rx_data  (i_rx_data),
        .i_rx_dv    (i_rx_dv),
        .o_sof      (sof),
        .o_byte_vld (byte_vld),
        .o_eof      (eof)
    );

    // Working registers (filled while the frame streams in)
    state_t      phase_q, phase_d;
    logic [10:0] n_q, n_d;
    logic        er_q, er_d, is_arp_q, is_arp_d, is_ipv4_q, is_ipv4_d;
    logic [47:0] dst_q, dst_d, src_q, src_d, sha_q, sha_d, tha_q, tha_d;
    logic [31:0] spa_q, spa_d, tpa_q, tpa_d;
    logic [15:0] htype_q, htype_d, ptype_q, ptype_d, oper_q, oper_d;
    logic [7:0]  etype_hi_q, etype_hi_d, hlen_q, hlen_d, plen_q, plen_d;

    // Output registers (loaded only in the pulse cycle)
    logic [47:0] dst_out_q, dst_out_d, src_out_q, src_out_d, sha_out_q, sha_out_d, tha_out_q, tha_out_d;
    logic [31:0] spa_out_q, spa_out_d, tpa_out_q, tpa_out_d;
    pkt_type_t   pkt_type_q, pkt_type_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic [15:0] etype_now;
    logic        len_bad, arp_bad, filt_bad, frame_bad;

    assign etype_now = {etype_hi_q, i_rx_data};
    assign len_bad   = (n_q < MIN_N) || (n_q > MAX_N);
    assign arp_bad   = is_arp_q && ((n_q < ARP_END_N) || (htype_q != ARP_HTYPE_ETH) ||
                       (ptype_q != ARP_PTYPE_IPV4) || (hlen_q != ARP_HLEN_ETH) ||
                       (plen_q != ARP_PLEN_IPV4) ||
                       ((oper_q != ARP_OPER_REQ) && (oper_q != ARP_OPER_REP)));
    assign filt_bad  = MAC_FILTER && (dst_q != LOCAL_MAC) && (dst_q != 48'hFFFF_FFFF_FFFF);
    assign frame_bad = er_q || len_bad || arp_bad || filt_bad;

    // Field capture while streaming, then classification and output load at end of frame
    always_comb begin
        phase_d    = phase_q;     n_d       = n_q;       er_d       = er_q;
        is_arp_d   = is_arp_q;    is_ipv4_d = is_ipv4_q;
        dst_d      = dst_q;       src_d     = src_q;     etype_hi_d = etype_hi_q;
        htype_d    = htype_q;     ptype_d   = ptype_q;   hlen_d     = hlen_q;
        plen_d     = plen_q;      oper_d    = oper_q;
        sha_d      = sha_q;       spa_d     = spa_q;     tha_d      = tha_q;   tpa_d = tpa_q;
        dst_out_d  = dst_out_q;   src_out_d = src_out_q;
        sha_out_d  = sha_out_q;   spa_out_d = spa_out_q;
        tha_out_d  = tha_out_q;   tpa_out_d = tpa_out_q;
        drop_cnt_d = drop_cnt_q;
        pkt_type_d = PKT_NONE;

        if (sof) begin
            phase_d   = ST_HDR;
            n_d       = 11'd0;
            er_d      = i_rx_er;
            is_arp_d  = 1'b0;
            is_ipv4_d = 1'b0;
        end else if (byte_vld) begin
            n_d = len_inc(n_q);
            if (i_rx_er) er_d = 1'b1;
            case (phase_q)
                ST_HDR: begin
                    if (n_q < 11'd6)       dst_d      = {dst_q[39:0], i_rx_data};
                    else if (n_q < 11'd12) src_d      = {src_q[39:0], i_rx_data};
                    else                   etype_hi_d = i_rx_data;
                    if (n_q == 11'd13) begin
                        is_arp_d  = (etype_now == ETH_ARP);
                        is_ipv4_d = (etype_now == ETH_IPV4);
                        phase_d   = (etype_now == ETH_ARP) ? ST_BODY : ST_DRAIN;
                    end
                end
                ST_BODY: begin
                    if (n_q < 11'd16)       htype_d = {htype_q[7:0], i_rx_data};
                    else if (n_q < 11'd18)  ptype_d = {ptype_q[7:0], i_rx_data};
                    else if (n_q == 11'd18) hlen_d  = i_rx_data;
                    else if (n_q == 11'd19) plen_d  = i_rx_data;
                    else if (n_q < 11'd22)  oper_d  = {oper_q[7:0], i_rx_data};
                    else if (n_q < 11'd28)  sha_d   = {sha_q[39:0], i_rx_data};
                    else if (n_q < 11'd32)  spa_d   = {spa_q[23:0], i_rx_data};
                    else if (n_q < 11'd38)  tha_d   = {tha_q[39:0], i_rx_data};
                    else                    tpa_d   = {tpa_q[23:0], i_rx_data};
                    if (n_q == 11'd41) phase_d = ST_DRAIN;
                end
                default: ;
            endcase
        end

        if (eof) begin
            if (frame_bad) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end else if (is_arp_q) begin
                pkt_type_d = (oper_q == ARP_OPER_REQ) ? PKT_ARP_REQ : PKT_ARP_REP;
                dst_out_d  = dst_q;  src_out_d = src_q;
                sha_out_d  = sha_q;  spa_out_d = spa_q;
                tha_out_d  = tha_q;  tpa_out_d = tpa_q;
            end else if (is_ipv4_q) begin
                pkt_type_d = PKT_IPV4;
                dst_out_d  = dst_q;  src_out_d = src_q;
                sha_out_d  = '0;     spa_out_d = '0;
                tha_out_d  = '0;     tpa_out_d = '0;
            end
        end
    end

    // All working and output state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= ST_HDR;  n_q       <= '0;  er_q       <= 1'b0;
            is_arp_q   <= 1'b0;    is_ipv4_q <= 1'b0;
            dst_q      <= '0;      src_q     <= '0;  etype_hi_q <= '0;
            htype_q    <= '0;      ptype_q   <= '0;  hlen_q     <= '0;
            plen_q     <= '0;      oper_q    <= '0;
            sha_q      <= '0;      spa_q     <= '0;  tha_q      <= '0;  tpa_q <= '0;
            dst_out_q  <= '0;      src_out_q <= '0;
            sha_out_q  <= '0;      spa_out_q <= '0;
            tha_out_q  <= '0;      tpa_out_q <= '0;
            pkt_type_q <= PKT_NONE;
            drop_cnt_q <= '0;
        end else begin
            phase_q    <= phase_d;    n_q       <= n_d;       er_q       <= er_d;
            is_arp_q   <= is_arp_d;   is_ipv4_q <= is_ipv4_d;
            dst_q      <= dst_d;      src_q     <= src_d;     etype_hi_q <= etype_hi_d;
            htype_q    <= htype_d;    ptype_q   <= ptype_d;   hlen_q     <= hlen_d;
            plen_q     <= plen_d;     oper_q    <= oper_d;
            sha_q      <= sha_d;      spa_q     <= spa_d;     tha_q      <= tha_d;   tpa_q <= tpa_d;
            dst_out_q  <= dst_out_d;  src_out_q <= src_out_d;
            sha_out_q  <= sha_out_d;  spa_out_q <= spa_out_d;
            tha_out_q  <= tha_out_d;  tpa_out_q <= tpa_out_d;
            pkt_type_q <= pkt_type_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_dst_mac  = dst_out_q;
    assign o_src_mac  = src_out_q;
    assign o_SHA      = sha_out_q;
    assign o_SPA      = spa_out_q;
    assign o_THA      = tha_out_q;
    assign o_TPA      = tpa_out_q;
    assign o_pkt_type = pkt_type_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_parser.sv
// Directed bench for eth_rx_parser: one unfiltered and one MAC-filtered instance on a shared stream.
// Latency: expects the type pulse exactly one cycle after dv first drops.
// Backpressure: none; the stream is driven one byte per cycle.
module tb_eth_rx_parser;
    import eth_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_dv = 1'b0;
    logic       rx_er = 1'b0;

    logic [47:0] o_dst_mac, o_src_mac, o_SHA, o_THA;
    logic [31:0] o_SPA, o_TPA;
    logic [1:0]  o_pkt_type;
    logic [15:0] o_drop_cnt;
    logic [47:0] f_dst_mac, f_src_mac, f_SHA, f_THA;
    logic [31:0] f_SPA, f_TPA;
    logic [1:0]  f_pkt_type;
    logic [15:0] f_drop_cnt;

    eth_rx_parser dut (
        .clk(clk), .rst_n(rst_n), .i_rx_data(rx_data), .i_rx_dv(rx_dv), .i_rx_er(rx_er),
        .o_dst_mac(o_dst_mac), .o_src_mac(o_src_mac), .o_SHA(o_SHA), .o_SPA(o_SPA),
        .o_THA(o_THA), .o_TPA(o_TPA), .o_pkt_type(o_pkt_type), .o_drop_cnt(o_drop_cnt)
    );

    eth_rx_parser #(.MAC_FILTER(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n), .i_rx_data(rx_data), .i_rx_dv(rx_dv), .i_rx_er(rx_er),
        .o_dst_mac(f_dst_mac), .o_src_mac(f_src_mac), .o_SHA(f_SHA), .o_SPA(f_SPA),
        .o_THA(f_THA), .o_TPA(f_TPA), .o_pkt_type(f_pkt_type), .o_drop_cnt(f_drop_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;
    int pulse_cnt_f = 0;

    logic [7:0] fb [0:2047];

    logic [1:0]  got_type, got_type_f;
    logic [47:0] got_dst, got_src, got_sha, got_tha;
    logic [31:0] got_spa, got_tpa;

    // Bench model of the held output registers and drop counters
    logic [47:0] m_dst = '0, m_src = '0, m_sha = '0, m_tha = '0;
    logic [31:0] m_spa = '0, m_tpa = '0;
    logic [15:0] exp_drop = '0, exp_drop_f = '0;

    typedef struct {
        string       name;
        int          len;
        int          er_idx;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] etype;
        logic [15:0] oper;
        logic [31:0] spa;
        logic [47:0] tha;
        logic [31:0] tpa;
        logic [1:0]  exp_type;
        bit          exp_bad;
    } vec_t;

    vec_t vt [12];

    // Count every pulse cycle of each instance
    always @(negedge clk) begin
        if (o_pkt_type != 2'b00) pulse_cnt++;
        if (f_pkt_type != 2'b00) pulse_cnt_f++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic dv, input logic er);
        @(posedge clk);
        #1;
        rx_data = d;
        rx_dv   = dv;
        rx_er   = er;
    endtask

    task automatic put(input int off, input int nbytes, input logic [47:0] val);
        for (int k = 0; k < nbytes; k++) fb[off + k] = val[8 * (nbytes - 1 - k) +: 8];
    endtask

    task automatic build(input vec_t v);
        for (int i = 0; i < 2048; i++) fb[i] = 8'((i * 7 + 3) & 8'h7F);
        put(0, 6, v.dst);
        put(6, 6, v.src);
        put(12, 2, 48'(v.etype));
        if (v.etype == ETH_ARP) begin
            put(14, 2, 48'h0001);
            put(16, 2, 48'h0800);
            put(18, 1, 48'h06);
            put(19, 1, 48'h04);
            put(20, 2, 48'(v.oper));
            put(22, 6, v.src);
            put(28, 4, 48'(v.spa));
            put(32, 6, v.tha);
            put(38, 4, 48'(v.tpa));
        end
    endtask

    // Preamble + SFD + frame, then sample both instances in the cycle after dv drops
    task automatic send_frame(input int len, input int er_idx);
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < len; i++) drive(fb[i], 1'b1, (i == er_idx));
        drive(8'h00, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        got_type = o_pkt_type;  got_type_f = f_pkt_type;
        got_dst  = o_dst_mac;   got_src    = o_src_mac;
        got_sha  = o_SHA;       got_spa    = o_SPA;
        got_tha  = o_THA;       got_tpa    = o_TPA;
        for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    // Shortest possible frame: one preamble byte, SFD, then idle
    task automatic runt();
        drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        int  p0, pf0;
        bit  filt;

        vt[0]  = '{"arp_req",    64,   -1, BCAST,              48'h021122334455, 16'h0806, 16'd1, 32'hC0A80001, 48'h0,             32'hC0A80002, 2'b01, 1'b0};
        vt[1]  = '{"arp_rep",    64,   -1, LOCAL,              48'h02AABBCCDDEE, 16'h0806, 16'd2, 32'hC0A80002, 48'h021122334455, 32'hC0A80001, 2'b10, 1'b0};
        vt[2]  = '{"ipv4",       100,  -1, 48'h021122334455,   48'h02CAFE000001, 16'h0800, 16'd0, 32'h0,        48'h0,             32'h0,        2'b11, 1'b0};
        vt[3]  = '{"arp_er30",   64,   30, BCAST,              48'h023333333333, 16'h0806, 16'd1, 32'h0A000001, 48'h0,             32'h0A000002, 2'b00, 1'b1};
        vt[4]  = '{"runt40",     40,   -1, LOCAL,              48'h024444444444, 16'h0800, 16'd0, 32'h0,        48'h0,             32'h0,        2'b00, 1'b1};
        vt[5]  = '{"giant1600",  1600, -1, LOCAL,              48'h025555555555, 16'h0800, 16'd0, 32'h0,        48'h0,             32'h0,        2'b00, 1'b1};
        vt[6]  = '{"ipv6",       80,   -1, LOCAL,              48'h026666666666, 16'h86DD, 16'd0, 32'h0,        48'h0,             32'h0,        2'b00, 1'b0};
        vt[7]  = '{"arp_oper3",  64,   -1, BCAST,              48'h027777777777, 16'h0806, 16'd3, 32'h01020304, 48'h0,             32'h05060708, 2'b00, 1'b1};
        vt[8]  = '{"ipv4_1518",  1518, -1, BCAST,              48'h02CAFE000002, 16'h0800, 16'd0, 32'h0,        48'h0,             32'h0,        2'b11, 1'b0};
        vt[9]  = '{"ipv4_63",    63,   -1, BCAST,              48'h02CAFE000009, 16'h0800, 16'd0, 32'h0,        48'h0,             32'h0,        2'b00, 1'b1};
        vt[10] = '{"ipv4_64",    64,   -1, LOCAL,              48'h02CAFE000003, 16'h0800, 16'd0, 32'h0,        48'h0,             32'h0,        2'b11, 1'b0};
        vt[11] = '{"uni_other",  64,   -1, 48'h020000000099,   48'h02CAFE000004, 16'h0800, 16'd0, 32'h0,        48'h0,             32'h0,        2'b11, 1'b0};

        // Reset held while a frame is already on the wire; release mid-preamble
        build(vt[0]);
        for (int i = 0; i < 3; i++) drive(8'h55, 1'b1, 1'b0);
        check("rst_type",  64'(o_pkt_type), 64'h0);
        check("rst_drop",  64'(o_drop_cnt), 64'h0);
        check("rst_dst",   64'(o_dst_mac),  64'h0);
        check("rst_spa",   64'(o_SPA),      64'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 64; i++) drive(fb[i], 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive(8'h00, 1'b0, 1'b0);
        check("rst_midframe_pulses", 64'(pulse_cnt),  64'd0);
        check("rst_midframe_drop",   64'(o_drop_cnt), 64'h0);

        // Table: each frame checked on both instances
        for (int t = 0; t < 12; t++) begin
            build(vt[t]);
            p0  = pulse_cnt;
            pf0 = pulse_cnt_f;
            send_frame(vt[t].len, vt[t].er_idx);
            filt = (vt[t].dst != LOCAL) && (vt[t].dst != BCAST);
            if (vt[t].exp_bad) exp_drop++;
            if (vt[t].exp_bad || filt) exp_drop_f++;
            if (vt[t].exp_type == 2'b01 || vt[t].exp_type == 2'b10) begin
                m_dst = vt[t].dst; m_src = vt[t].src; m_sha = vt[t].src;
                m_spa = vt[t].spa; m_tha = vt[t].tha; m_tpa = vt[t].tpa;
            end else if (vt[t].exp_type == 2'b11) begin
                m_dst = vt[t].dst; m_src = vt[t].src;
                m_sha = '0; m_spa = '0; m_tha = '0; m_tpa = '0;
            end
            check({vt[t].name, "_type"},    64'(got_type),   64'(vt[t].exp_type));
            check({vt[t].name, "_type_f"},  64'(got_type_f), filt ? 64'h0 : 64'(vt[t].exp_type));
            check({vt[t].name, "_npulse"},  64'(pulse_cnt - p0),    (vt[t].exp_type != 2'b00) ? 64'd1 : 64'd0);
            check({vt[t].name, "_npulse_f"},64'(pulse_cnt_f - pf0), (!filt && vt[t].exp_type != 2'b00) ? 64'd1 : 64'd0);
            check({vt[t].name, "_drop"},    64'(o_drop_cnt), 64'(exp_drop));
            check({vt[t].name, "_drop_f"},  64'(f_drop_cnt), 64'(exp_drop_f));
            check({vt[t].name, "_dst"},     64'(got_dst), 64'(m_dst));
            check({vt[t].name, "_src"},     64'(got_src), 64'(m_src));
            check({vt[t].name, "_sha"},     64'(got_sha), 64'(m_sha));
            check({vt[t].name, "_spa"},     64'(got_spa), 64'(m_spa));
            check({vt[t].name, "_tha"},     64'(got_tha), 64'(m_tha));
            check({vt[t].name, "_tpa"},     64'(got_tpa), 64'(m_tpa));
            if (t == 5) check("three_drops", 64'(o_drop_cnt), 64'd3);
        end

        // Drop counter wrap: run up to 0xFFFF with minimal runts, then one more
        while (exp_drop != 16'hFFFF) begin
            runt();
            exp_drop++;
            exp_drop_f++;
        end
        check("drop_ffff", 64'(o_drop_cnt), 64'hFFFF);
        runt();
        exp_drop++;
        exp_drop_f++;
        check("drop_wrap",   64'(o_drop_cnt), 64'h0000);
        check("drop_wrap_f", 64'(f_drop_cnt), 64'(exp_drop_f));

        // Unknown ethertype after the wrap: no pulse, count unchanged
        build(vt[6]);
        p0 = pulse_cnt;
        send_frame(vt[6].len, -1);
        check("ipv6_after_wrap_type",   64'(got_type),        64'h0);
        check("ipv6_after_wrap_pulses", 64'(pulse_cnt - p0),  64'd0);
        check("ipv6_after_wrap_drop",   64'(o_drop_cnt),      64'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
